fft_frame_sched: RTL and testbench
==================================

Name: fft_frame_sched

Overview:
Frame scheduler that owns the 128-entry, 26-bit dual-port spectrum BRAM shared by the audio sample loader, the fft128 engine and the display reader. It runs a fixed cycle: fill 128 samples, start the FFT, wait for completion, then hold the log spectrum for the display until released. It muxes the BRAM ports to exactly one owner per state.

Parameters:
DECIM, 1, keep one of every DECIM accepted sample strobes (1..255)
SMP_W, 12, input sample width, two's complement, at most 13

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
smp_valid  in  1  one-cycle sample strobe
smp_data  in  SMP_W  signed audio sample
fft_start  out  1  one-cycle start pulse to the FFT engine
fft_busy  in  1  FFT engine busy
fft_we_a, fft_we_b  in  1 each  FFT engine RAM write enables
fft_addr_a, fft_addr_b  in  7 each  FFT engine RAM addresses
fft_din_a, fft_din_b  in  26 each  FFT engine RAM write data
ram_we_a, ram_we_b  out  1 each  BRAM write enables
ram_addr_a, ram_addr_b  out  7 each  BRAM addresses
ram_din_a, ram_din_b  out  26 each  BRAM write data
ram_dout_a  in  26  BRAM port A read data; the FFT engine takes both dout buses directly
disp_addr  in  7  display bin address
disp_data  out  7  log magnitude, bits [11:5] of the bin word
disp_valid  out  1  disp_data valid for the previous cycle's disp_addr
frame_ready  out  1  spectrum held and readable
disp_done  in  1  display releases the frame
drop_cnt  out  16  saturating count of discarded samples

Behaviour:
- States: FILL, START, WAIT, HOLD. Reset enters FILL with fill_cnt=0, decim_cnt=0 and drop_cnt=0. All outputs are 0 at reset.
- FILL
  - Owns port A. On smp_valid: decim_cnt increments and wraps at DECIM-1.
  - When the strobe is kept (decim_cnt==0): ram_we_a=1 in the same cycle, ram_addr_a=fill_cnt, ram_din_a={13'd0, sign-extended sample to 13 bits}, and fill_cnt increments.
  - Port B is idle (we=0).
  - The kept write with fill_cnt==127 moves to START. fill_cnt wraps to 0.
- START: fft_start=1 for exactly one cycle, then WAIT. RAM ports are driven from the fft_* inputs from START onward.
- WAIT
  - RAM is fully passed through from the FFT engine.
  - fft_busy is ignored in the first WAIT cycle, because busy rises one cycle after start.
  - From then on, fft_busy==0 moves to HOLD.
  - A 2047-cycle watchdog also forces HOLD.
- HOLD
  - frame_ready=1. Port A is read-only: ram_addr_a=disp_addr, we=0.
  - disp_data is registered from ram_dout_a[11:5] one cycle after the address; disp_valid=1 from the second HOLD cycle.
  - disp_done moves to FILL, and frame_ready drops the next cycle.
- Drops: any smp_valid outside FILL increments drop_cnt, which saturates at 0xFFFF. decim_cnt does not advance on a drop.
- Simultaneous events:
  - disp_done outside HOLD is ignored.
  - smp_valid in the same cycle as the HOLD to FILL transition is dropped.
- rst mid-frame: returns to FILL immediately, fft_start=0, no RAM write in the reset cycle. The FFT engine is reset by the same rst.

Optional Feature:
FFT_BITREV_EN:
- Defined: FILL writes each sample to address bitrev7(fill_cnt).
- Undefined: natural order.
- Either way, HOLD reads use disp_addr unmodified.

Decomposition:
- Package fft_sched_pkg: state encoding, N_PTS=128, ADDR_W=7, WORD_W=26, FIELD_W=13, WDOG_MAX=2047, bitrev7 function.
- One sub-module, fft_ram_mux: the combinational port mux, selected by state.

Test Plan:
- DECIM=1, samples 0..127 strobed every 4 cycles:
  - Port A writes addresses 0..127 with din={13'd0, n}.
  - fft_start pulses once, 1 cycle after the 128th write.
- Sample -1 (SMP_W=12) -> ram_din_a = 0x0001FFF, i.e. the low 13 bits are all ones.
- Stub FFT with busy high for 1474 cycles after start:
  - frame_ready rises 1 cycle after busy falls.
  - fft_* inputs appear on the ram_* outputs throughout WAIT.
- HOLD, BRAM word 0x0000FE0 at bin 5, disp_addr=5 -> disp_data=0x7F one cycle later, with disp_valid=1.
- 10 smp_valid in HOLD, then disp_done:
  - drop_cnt=10.
  - The next kept sample writes address 0.
- DECIM=3: 384 strobes fill one frame. rst asserted at fill_cnt=60 -> fill_cnt=0 and drop_cnt=0, with no fft_start.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT frame scheduler: frame geometry, BRAM word layout,
// scheduler state encoding and the 7-bit bit-reversal helper.
package fft_sched_pkg;

  localparam int unsigned N_PTS    = 128;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned WORD_W   = 26;
  localparam int unsigned FIELD_W  = 13;
  localparam int unsigned WDOG_MAX = 2047;
  localparam int unsigned WDOG_W   = 11;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } sched_state_e;

  function automatic logic [ADDR_W-1:0] bitrev7(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_ram_mux.sv
// Combinational BRAM port mux for the FFT frame scheduler. Exactly one owner drives the
// spectrum BRAM in each scheduler state:
//   StFill          : port A from the sample loader, port B idle
//   StStart, StWait : both ports passed through from the FFT engine
//   StHold          : port A read-only at the display address, port B idle
// While hold_off_i is high (reset) every output is forced to zero.
// Ports:
//   state_i            scheduler state (sched_state_e encoding)
//   hold_off_i         force all RAM controls idle
//   fill_we_i/addr_i/din_i   loader write request
//   disp_addr_i        display bin address
//   fft_we/addr/din_a/b_i    FFT engine RAM requests
//   ram_we/addr/din_a/b_o    BRAM port controls
module fft_ram_mux
  import fft_sched_pkg::*;
(
  input  logic [1:0]        state_i,
  input  logic              hold_off_i,
  input  logic              fill_we_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [WORD_W-1:0] fill_din_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  input  logic              fft_we_a_i,
  input  logic              fft_we_b_i,
  input  logic [ADDR_W-1:0] fft_addr_a_i,
  input  logic [ADDR_W-1:0] fft_addr_b_i,
  input  logic [WORD_W-1:0] fft_din_a_i,
  input  logic [WORD_W-1:0] fft_din_b_i,
  output logic              ram_we_a_o,
  output logic              ram_we_b_o,
  output logic [ADDR_W-1:0] ram_addr_a_o,
  output logic [ADDR_W-1:0] ram_addr_b_o,
  output logic [WORD_W-1:0] ram_din_a_o,
  output logic [WORD_W-1:0] ram_din_b_o
);

  always_comb begin
    ram_we_a_o   = 1'b0;
    ram_we_b_o   = 1'b0;
    ram_addr_a_o = '0;
    ram_addr_b_o = '0;
    ram_din_a_o  = '0;
    ram_din_b_o  = '0;
    if (!hold_off_i) begin
      case (state_i)
        StFill: begin
          ram_we_a_o   = fill_we_i;
          ram_addr_a_o = fill_addr_i;
          ram_din_a_o  = fill_din_i;
        end
        StStart, StWait: begin
          ram_we_a_o   = fft_we_a_i;
          ram_we_b_o   = fft_we_b_i;
          ram_addr_a_o = fft_addr_a_i;
          ram_addr_b_o = fft_addr_b_i;
          ram_din_a_o  = fft_din_a_i;
          ram_din_b_o  = fft_din_b_i;
        end
        StHold: begin
          ram_addr_a_o = disp_addr_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler owning the 128 x 26-bit spectrum BRAM shared by the sample loader, the
// fft128 engine and the display reader. Cycle: fill 128 samples, pulse fft_start, wait for
// the engine (busy low or watchdog), then hold the spectrum for the display until released.
// Optional feature: define FFT_BITREV_EN to store samples at bitrev7(fill index).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   smp_valid, smp_data      sample strobe and signed sample (SMP_W bits)
//   fft_start, fft_busy      FFT engine handshake
//   fft_we/addr/din_a/b      FFT engine RAM requests
//   ram_we/addr/din_a/b      BRAM port controls; ram_dout_a is port A read data
//   disp_addr, disp_data, disp_valid   display read path (disp_data = word[11:5])
//   frame_ready, disp_done   spectrum held / released
//   drop_cnt                 saturating count of samples discarded outside FILL
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int unsigned DECIM = 1,
  parameter int unsigned SMP_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp_valid,
  input  logic [SMP_W-1:0] smp_data,
  output logic             fft_start,
  input  logic             fft_busy,
  input  logic             fft_we_a,
  input  logic             fft_we_b,
  input  logic [6:0]       fft_addr_a,
  input  logic [6:0]       fft_addr_b,
  input  logic [25:0]      fft_din_a,
  input  logic [25:0]      fft_din_b,
  output logic             ram_we_a,
  output logic             ram_we_b,
  output logic [6:0]       ram_addr_a,
  output logic [6:0]       ram_addr_b,
  output logic [25:0]      ram_din_a,
  output logic [25:0]      ram_din_b,
  input  logic [25:0]      ram_dout_a,
  input  logic [6:0]       disp_addr,
  output logic [6:0]       disp_data,
  output logic             disp_valid,
  output logic             frame_ready,
  input  logic             disp_done,
  output logic [15:0]      drop_cnt
);

  localparam logic [7:0]        DecimLast = 8'(DECIM - 1);
  localparam logic [ADDR_W-1:0] FillLast  = ADDR_W'(N_PTS - 1);
  localparam logic [WDOG_W-1:0] WdogLast  = WDOG_W'(WDOG_MAX - 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [7:0]        decim_q, decim_d;
  logic [15:0]       drop_q, drop_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              disp_valid_q;

  logic              keep;
  logic [ADDR_W-1:0] fill_addr;
  logic [FIELD_W-1:0] smp_sext;
  logic [WORD_W-1:0] fill_din;

  assign smp_sext = FIELD_W'($signed(smp_data));
  assign fill_din = WORD_W'(smp_sext);

`ifdef FFT_BITREV_EN
  assign fill_addr = bitrev7(fill_q);
`else
  assign fill_addr = fill_q;
`endif

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    decim_d = decim_q;
    drop_d  = drop_q;
    wdog_d  = wdog_q;
    keep    = 1'b0;
    case (state_q)
      StFill: begin
        if (smp_valid) begin
          decim_d = (decim_q == DecimLast) ? 8'd0 : decim_q + 8'd1;
          if (decim_q == 8'd0) begin
            keep   = 1'b1;
            fill_d = fill_q + 7'd1;
            if (fill_q == FillLast) state_d = StStart;
          end
        end
      end
      StStart: begin
        state_d = StWait;
        wdog_d  = '0;
      end
      StWait: begin
        wdog_d = wdog_q + 11'd1;
        // Busy rises one cycle after start, so the first WAIT cycle (wdog_q == 0) ignores it.
        if ((wdog_q != '0 && !fft_busy) || wdog_q == WdogLast) state_d = StHold;
      end
      StHold: begin
        if (disp_done) state_d = StFill;
      end
      default: state_d = StFill;
    endcase
    // Any strobe outside FILL is discarded, including the HOLD->FILL transition cycle.
    if (smp_valid && state_q != StFill && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      fill_q       <= '0;
      decim_q      <= '0;
      drop_q       <= '0;
      wdog_q       <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      decim_q      <= decim_d;
      drop_q       <= drop_d;
      wdog_q       <= wdog_d;
      disp_valid_q <= (state_q == StHold);
    end
  end

  fft_ram_mux u_ram_mux (
    .state_i      (state_q),
    .hold_off_i   (rst),
    .fill_we_i    (keep),
    .fill_addr_i  (fill_addr),
    .fill_din_i   (fill_din),
    .disp_addr_i  (disp_addr),
    .fft_we_a_i   (fft_we_a),
    .fft_we_b_i   (fft_we_b),
    .fft_addr_a_i (fft_addr_a),
    .fft_addr_b_i (fft_addr_b),
    .fft_din_a_i  (fft_din_a),
    .fft_din_b_i  (fft_din_b),
    .ram_we_a_o   (ram_we_a),
    .ram_we_b_o   (ram_we_b),
    .ram_addr_a_o (ram_addr_a),
    .ram_addr_b_o (ram_addr_b),
    .ram_din_a_o  (ram_din_a),
    .ram_din_b_o  (ram_din_b)
  );

  // BRAM read data is already one cycle behind the address, so the valid flag is the
  // registered element of the display path.
  assign disp_data   = disp_valid_q ? ram_dout_a[11:5] : 7'd0;
  assign disp_valid  = disp_valid_q;
  assign fft_start   = (state_q == StStart) && !rst;
  assign frame_ready = (state_q == StHold) && !rst;
  assign drop_cnt    = drop_q;

  logic unused_dout;
  assign unused_dout = ^{ram_dout_a[25:12], ram_dout_a[4:0]};

endmodule

// File: tb/tb_fft_frame_sched.sv
module tb_fft_frame_sched;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with DECIM=1 ----------------
  logic        rst = 1'b1;
  logic        smp_valid = 1'b0;
  logic [11:0] smp_data = '0;
  logic        fft_start;
  logic        fft_busy;
  logic        fft_we_a = 1'b0, fft_we_b = 1'b0;
  logic [6:0]  fft_addr_a = '0, fft_addr_b = '0;
  logic [25:0] fft_din_a = '0, fft_din_b = '0;
  logic        ram_we_a, ram_we_b;
  logic [6:0]  ram_addr_a, ram_addr_b;
  logic [25:0] ram_din_a, ram_din_b;
  logic [25:0] ram_dout_a = '0;
  logic [6:0]  disp_addr = '0;
  logic [6:0]  disp_data;
  logic        disp_valid, frame_ready;
  logic        disp_done = 1'b0;
  logic [15:0] drop_cnt;

  fft_frame_sched #(.DECIM(1), .SMP_W(12)) dut (
    .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data),
    .fft_start(fft_start), .fft_busy(fft_busy),
    .fft_we_a(fft_we_a), .fft_we_b(fft_we_b), .fft_addr_a(fft_addr_a), .fft_addr_b(fft_addr_b),
    .fft_din_a(fft_din_a), .fft_din_b(fft_din_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b), .ram_dout_a(ram_dout_a),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .frame_ready(frame_ready), .disp_done(disp_done), .drop_cnt(drop_cnt)
  );

  // BRAM model with registered port-A read and a bench poke port.
  logic [25:0] mem [128];
  logic        poke_en = 1'b0;
  logic [6:0]  poke_addr = '0;
  logic [25:0] poke_data = '0;
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    if (poke_en) mem[poke_addr] <= poke_data;
    ram_dout_a <= mem[ram_addr_a];
  end

  // Stub FFT: busy high for 1474 cycles starting the cycle after fft_start.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (fft_start) busy_cnt <= 1474;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign fft_busy = (busy_cnt != 0);

  int start1_cnt = 0;
  always @(posedge clk) if (fft_start === 1'b1) start1_cnt <= start1_cnt + 1;

  // ---------------- DUT with DECIM=3 ----------------
  logic        rst3 = 1'b1;
  logic        smp_valid3 = 1'b0;
  logic [11:0] smp_data3 = '0;
  logic        fft_start3;
  logic        zero1 = 1'b0;
  logic [6:0]  zero7 = '0;
  logic [25:0] zero26 = '0;
  logic        ram_we_a3, ram_we_b3;
  logic [6:0]  ram_addr_a3, ram_addr_b3;
  logic [25:0] ram_din_a3, ram_din_b3;
  logic [6:0]  disp_data3;
  logic        disp_valid3, frame_ready3;
  logic        disp_done3 = 1'b0;
  logic [15:0] drop_cnt3;

  fft_frame_sched #(.DECIM(3), .SMP_W(12)) dut3 (
    .clk(clk), .rst(rst3), .smp_valid(smp_valid3), .smp_data(smp_data3),
    .fft_start(fft_start3), .fft_busy(zero1),
    .fft_we_a(zero1), .fft_we_b(zero1), .fft_addr_a(zero7), .fft_addr_b(zero7),
    .fft_din_a(zero26), .fft_din_b(zero26),
    .ram_we_a(ram_we_a3), .ram_we_b(ram_we_b3), .ram_addr_a(ram_addr_a3),
    .ram_addr_b(ram_addr_b3), .ram_din_a(ram_din_a3), .ram_din_b(ram_din_b3),
    .ram_dout_a(zero26), .disp_addr(zero7), .disp_data(disp_data3), .disp_valid(disp_valid3),
    .frame_ready(frame_ready3), .disp_done(disp_done3), .drop_cnt(drop_cnt3)
  );

  int start3_cnt = 0;
  always @(posedge clk) if (fft_start3 === 1'b1) start3_cnt <= start3_cnt + 1;

  // ---------------- helpers ----------------
  function automatic logic [6:0] exp_addr(input int n);
    logic [6:0] a;
    logic [6:0] r;
    a = 7'(n);
`ifdef FFT_BITREV_EN
    for (int i = 0; i < 7; i++) r[i] = a[6-i];
`else
    r = a;
`endif
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1; smp_valid = 1'b1; smp_data = 12'h005;
    cyc(); cyc();
    #1;
    checks++; if (ram_we_a !== 1'b0) begin failures++;
      $display("FAIL reset_we_a: got %0h expected 0", ram_we_a); end
    checks++; if (fft_start !== 1'b0) begin failures++;
      $display("FAIL reset_fft_start: got %0h expected 0", fft_start); end
    checks++; if (frame_ready !== 1'b0) begin failures++;
      $display("FAIL reset_frame_ready: got %0h expected 0", frame_ready); end
    checks++; if (drop_cnt !== 16'd0) begin failures++;
      $display("FAIL reset_drop_cnt: got %0h expected 0", drop_cnt); end
    checks++; if (disp_valid !== 1'b0 || disp_data !== 7'd0) begin failures++;
      $display("FAIL reset_disp: got valid=%0h data=%0h expected 0/0", disp_valid, disp_data); end
    rst = 1'b0; rst3 = 1'b0; smp_valid = 1'b0;
    cyc();
  endtask

  task automatic test_fill();
    for (int n = 0; n < 128; n++) begin
      smp_valid = 1'b1; smp_data = 12'(n);
      #1;
      checks++;
      if (ram_we_a !== 1'b1 || ram_addr_a !== exp_addr(n) || ram_din_a !== 26'(n)
          || ram_we_b !== 1'b0) begin
        failures++;
        $display("FAIL fill_write[%0d]: got we=%0h addr=%0h din=%0h web=%0h expected 1/%0h/%0h/0",
                 n, ram_we_a, ram_addr_a, ram_din_a, ram_we_b, exp_addr(n), n);
      end
      checks++; if (fft_start !== 1'b0) begin failures++;
        $display("FAIL fill_no_start[%0d]: got %0h expected 0", n, fft_start); end
      cyc();
      smp_valid = 1'b0;
      if (n < 127) begin cyc(); cyc(); cyc(); end
    end
    #1;
    checks++; if (fft_start !== 1'b1) begin failures++;
      $display("FAIL start_pulse: got %0h expected 1", fft_start); end
    cyc();
    checks++; if (fft_start !== 1'b0) begin failures++;
      $display("FAIL start_one_cycle: got %0h expected 0", fft_start); end
    checks++; if (start1_cnt !== 1) begin failures++;
      $display("FAIL start_count: got %0d expected 1", start1_cnt); end
  endtask

  task automatic test_wait();
    int fall_at = -1;
    int rise_at = -1;
    int bad = 0;
    // Now in the first WAIT cycle (index 1; the START cycle is index 0).
    for (int i = 1; i <= 3000; i++) begin
      fft_we_a = i[0]; fft_we_b = i[1];
      fft_addr_a = i[6:0]; fft_addr_b = 7'(i * 3);
      fft_din_a = 26'(i * 12345); fft_din_b = ~26'(i);
      #1;
      if (frame_ready === 1'b1) begin rise_at = i; break; end
      if (fft_busy === 1'b0 && fall_at < 0) fall_at = i;
      if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b} !==
          {fft_we_a, fft_we_b, fft_addr_a, fft_addr_b, fft_din_a, fft_din_b}) bad++;
      cyc();
    end
    fft_we_a = 1'b0; fft_we_b = 1'b0; fft_addr_a = '0; fft_addr_b = '0;
    fft_din_a = '0; fft_din_b = '0;
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL wait_passthrough: got %0d bad cycles expected 0", bad); end
    checks++; if (rise_at !== 1476) begin failures++;
      $display("FAIL ready_cycle: got %0d expected 1476", rise_at); end
    checks++; if (rise_at - fall_at !== 1) begin failures++;
      $display("FAIL ready_after_busy: got %0d expected 1", rise_at - fall_at); end
  endtask

  task automatic test_hold_read();
    poke_en = 1'b1; poke_addr = 7'd5; poke_data = 26'h0000FE0;
    cyc();
    poke_addr = 7'd9; poke_data = 26'h00000A0;
    cyc();
    poke_en = 1'b0;
    disp_addr = 7'd5;
    #1;
    checks++; if (ram_addr_a !== 7'd5 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
      failures++;
      $display("FAIL hold_port_a: got addr=%0h we=%0h web=%0h expected 5/0/0",
               ram_addr_a, ram_we_a, ram_we_b);
    end
    cyc();
    disp_addr = 7'd9;
    #1;
    checks++; if (disp_data !== 7'h7F || disp_valid !== 1'b1) begin failures++;
      $display("FAIL disp_bin5: got data=%0h valid=%0h expected 7f/1", disp_data, disp_valid); end
    cyc();
    #1;
    checks++; if (disp_data !== 7'h05) begin failures++;
      $display("FAIL disp_bin9: got %0h expected 5", disp_data); end
  endtask

  task automatic test_drops_release();
    for (int k = 0; k < 10; k++) begin
      smp_valid = 1'b1; cyc(); smp_valid = 1'b0; cyc();
    end
    checks++; if (drop_cnt !== 16'd10) begin failures++;
      $display("FAIL drop_cnt_10: got %0d expected 10", drop_cnt); end
    checks++; if (frame_ready !== 1'b1) begin failures++;
      $display("FAIL still_held: got %0h expected 1", frame_ready); end
    // Release with a simultaneous strobe: strobe is dropped.
    disp_done = 1'b1; smp_valid = 1'b1;
    cyc();
    disp_done = 1'b0; smp_valid = 1'b0;
    #1;
    checks++; if (frame_ready !== 1'b0) begin failures++;
      $display("FAIL ready_drop: got %0h expected 0", frame_ready); end
    checks++; if (drop_cnt !== 16'd11) begin failures++;
      $display("FAIL drop_on_release: got %0d expected 11", drop_cnt); end
    // disp_done in FILL is ignored.
    disp_done = 1'b1; cyc(); disp_done = 1'b0;
    smp_valid = 1'b1; smp_data = 12'hFFF;
    #1;
    checks++; if (ram_we_a !== 1'b1 || ram_addr_a !== exp_addr(0) || ram_din_a !== 26'h0001FFF)
    begin
      failures++;
      $display("FAIL neg1_addr0: got we=%0h addr=%0h din=%0h expected 1/%0h/1fff",
               ram_we_a, ram_addr_a, ram_din_a, exp_addr(0));
    end
    cyc();
    smp_data = 12'h800;
    #1;
    checks++; if (ram_we_a !== 1'b1 || ram_addr_a !== exp_addr(1) || ram_din_a !== 26'h0001800)
    begin
      failures++;
      $display("FAIL min_addr1: got we=%0h addr=%0h din=%0h expected 1/%0h/1800",
               ram_we_a, ram_addr_a, ram_din_a, exp_addr(1));
    end
    cyc();
    smp_valid = 1'b0;
    #1;
    checks++; if (drop_cnt !== 16'd11 || frame_ready !== 1'b0) begin failures++;
      $display("FAIL fill_no_drop: got drop=%0d ready=%0h expected 11/0", drop_cnt, frame_ready);
    end
  endtask

  task automatic test_decim3_reset();
    int kept = 0;
    int bad = 0;
    int n = 0;
    logic exp_keep;
    for (int s = 0; s < 384; s++) begin
      smp_valid3 = 1'b1; smp_data3 = 12'(s);
      #1;
      exp_keep = (s < 382) && (s % 3 == 0);
      if (ram_we_a3 !== exp_keep) bad++;
      if (exp_keep && ram_addr_a3 !== exp_addr(kept)) bad++;
      if (exp_keep) kept++;
      cyc();
      smp_valid3 = 1'b0;
      cyc();
    end
    checks++; if (bad !== 0 || kept !== 128) begin failures++;
      $display("FAIL decim3_frame: got bad=%0d kept=%0d expected 0/128", bad, kept); end
    checks++; if (start3_cnt !== 1) begin failures++;
      $display("FAIL decim3_start: got %0d expected 1", start3_cnt); end
    checks++; if (drop_cnt3 !== 16'd2 || frame_ready3 !== 1'b1) begin failures++;
      $display("FAIL decim3_hold: got drop=%0d ready=%0h expected 2/1", drop_cnt3, frame_ready3);
    end
    disp_done3 = 1'b1; cyc(); disp_done3 = 1'b0;
    // decim_cnt is 1 here, so the 60th kept write lands on strobe 180.
    kept = 0;
    while (kept < 60 && n < 400) begin
      smp_valid3 = 1'b1;
      #1;
      if (ram_we_a3 === 1'b1) kept++;
      cyc();
      smp_valid3 = 1'b0;
      cyc();
      n++;
    end
    checks++; if (n !== 180) begin failures++;
      $display("FAIL decim3_strobes_to_60: got %0d expected 180", n); end
    rst3 = 1'b1; smp_valid3 = 1'b1;
    #1;
    checks++; if (ram_we_a3 !== 1'b0 || fft_start3 !== 1'b0) begin failures++;
      $display("FAIL rst_cycle_quiet: got we=%0h start=%0h expected 0/0", ram_we_a3, fft_start3);
    end
    cyc();
    rst3 = 1'b0; smp_valid3 = 1'b0;
    #1;
    checks++; if (drop_cnt3 !== 16'd0 || frame_ready3 !== 1'b0) begin failures++;
      $display("FAIL rst_clears: got drop=%0d ready=%0h expected 0/0", drop_cnt3, frame_ready3);
    end
    smp_valid3 = 1'b1; smp_data3 = 12'h123;
    #1;
    checks++; if (ram_we_a3 !== 1'b1 || ram_addr_a3 !== exp_addr(0) || ram_din_a3 !== 26'h0000123)
    begin
      failures++;
      $display("FAIL rst_refill: got we=%0h addr=%0h din=%0h expected 1/%0h/123",
               ram_we_a3, ram_addr_a3, ram_din_a3, exp_addr(0));
    end
    cyc();
    smp_valid3 = 1'b0;
    cyc(); cyc();
    checks++; if (start3_cnt !== 1) begin failures++;
      $display("FAIL rst_no_start: got %0d expected 1", start3_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wait();
    test_hold_read();
    test_drops_release();
    test_decim3_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
